dbus_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream data-bus slave port (memory/coherence controller) among N_CPU CPU data-bus interfaces (dbiu).
- Upstream side uses the same flat req/adr/dat/we/sel/ack bundle as the top-level CPU ports.
- Downstream side is a single-outstanding req/ack bus.
- Latches the winner's request, holds the grant until the slave acks, returns data/ack to the winner only, then waits for that requester to drop req before re-arbitrating.

---
 rtl/dbus_rr_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_dbus_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding data-bus slave among N_CPU requesters.
// Optional watchdog: define ARB_TIMEOUT_EN to add err_dbiu2m and a BUSY timeout.
module dbus_rr_arbiter #(
    parameter int N_CPU          = 2,
    parameter int DBUS_AW        = 32,
    parameter int DBUS_DW        = 64,
    parameter int DBUS_ISEL      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [N_CPU-1:0]                req_m2dbiu,
    input  logic [N_CPU*DBUS_AW-1:0]        adr_m2dbiu_flat,
    input  logic [N_CPU*DBUS_DW-1:0]        dat_m2dbiu_flat,
    input  logic [N_CPU-1:0]                we_m2dbiu,
    input  logic [N_CPU*DBUS_ISEL-1:0]      sel_m2dbiu_flat,
    output logic [N_CPU*DBUS_DW-1:0]        dat_dbiu2m_flat,
    output logic [N_CPU-1:0]                ack_dbiu2m,
    output logic                            req_arb2s,
    output logic [DBUS_AW-1:0]              adr_arb2s,
    output logic [DBUS_DW-1:0]              dat_arb2s,
    output logic                            we_arb2s,
    output logic [DBUS_ISEL-1:0]            sel_arb2s,
    input  logic [DBUS_DW-1:0]              dat_s2arb,
    input  logic                            ack_s2arb,
    output logic [$clog2(N_CPU)-1:0]        grant_id,
    output logic                            busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic [N_CPU-1:0]                err_dbiu2m
`endif
);

    localparam int GW = $clog2(N_CPU);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [GW-1:0]              last_q, last_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic                       req_q, req_d;
    logic [DBUS_AW-1:0]         adr_q, adr_d;
    logic [DBUS_DW-1:0]         dat_q, dat_d;
    logic                       we_q, we_d;
    logic [DBUS_ISEL-1:0]       sel_q, sel_d;
    logic [N_CPU-1:0]           ack_q, ack_d;
    logic [N_CPU*DBUS_DW-1:0]   rdat_q, rdat_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [N_CPU-1:0]           err_q, err_d;
`endif

    // Winner search starts one past the last served requester and wraps at N_CPU-1.
    logic          any_req;
    logic [GW-1:0] win;

    always_comb begin : arb_scan
        int idx;
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 1; k <= N_CPU; k++) begin
            idx = int'(last_q) + k;
            if (idx >= N_CPU) idx = idx - N_CPU;
            if (!any_req && req_m2dbiu[GW'(idx)]) begin
                any_req = 1'b1;
                win     = GW'(idx);
            end
        end
    end

    // Winner's upstream fields, selected with constant slices only.
    logic [DBUS_AW-1:0]   win_adr;
    logic [DBUS_DW-1:0]   win_dat;
    logic                 win_we;
    logic [DBUS_ISEL-1:0] win_sel;

    always_comb begin
        win_adr = '0;
        win_dat = '0;
        win_we  = 1'b0;
        win_sel = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (win == GW'(i)) begin
                win_adr = adr_m2dbiu_flat[i*DBUS_AW +: DBUS_AW];
                win_dat = dat_m2dbiu_flat[i*DBUS_DW +: DBUS_DW];
                win_we  = we_m2dbiu[i];
                win_sel = sel_m2dbiu_flat[i*DBUS_ISEL +: DBUS_ISEL];
            end
        end
    end

    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        req_d   = req_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        ack_d   = '0;
        rdat_d  = rdat_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = win;
                    adr_d   = win_adr;
                    dat_d   = win_dat;
                    we_d    = win_we;
                    sel_d   = win_sel;
                    req_d   = 1'b1;
                    state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_BUSY: begin
                if (ack_s2arb) begin
                    for (int i = 0; i < N_CPU; i++) begin
                        if (grant_q == GW'(i)) begin
                            ack_d[i] = 1'b1;
                            rdat_d[i*DBUS_DW +: DBUS_DW] = we_q ? '0 : dat_s2arb;
                        end
                    end
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                // An ack arriving on the expiry cycle takes the branch above and wins.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    for (int i = 0; i < N_CPU; i++) begin
                        if (grant_q == GW'(i)) begin
                            ack_d[i] = 1'b1;
                            err_d[i] = 1'b1;
                            rdat_d[i*DBUS_DW +: DBUS_DW] = '1;
                        end
                    end
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            ST_RELEASE: begin
                if (!req_m2dbiu[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous; it only takes effect on a rising clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= GW'(N_CPU - 1);
            grant_q <= '0;
            req_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            ack_q   <= '0;
            rdat_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign req_arb2s       = req_q;
    assign adr_arb2s       = adr_q;
    assign dat_arb2s       = dat_q;
    assign we_arb2s        = we_q;
    assign sel_arb2s       = sel_q;
    assign ack_dbiu2m      = ack_q;
    assign dat_dbiu2m_flat = rdat_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q != ST_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign err_dbiu2m      = err_q;
`endif

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Directed bench for dbus_rr_arbiter: load, store, contention rotation, field hold, reset, timeout.
// The watchdog scenario is compiled only with ARB_TIMEOUT_EN defined.
module tb_dbus_rr_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int TMO = 8;

    logic                clk = 1'b0;
    logic                resetn;
    logic [N-1:0]        req;
    logic [N*AW-1:0]     adr_flat;
    logic [N*DW-1:0]     dat_flat;
    logic [N-1:0]        we;
    logic [N*SW-1:0]     sel_flat;
    logic [N*DW-1:0]     rdat_flat;
    logic [N-1:0]        ack_m;
    logic                req_s;
    logic [AW-1:0]       adr_s;
    logic [DW-1:0]       dat_s;
    logic                we_s;
    logic [SW-1:0]       sel_s;
    logic [DW-1:0]       dat_s2arb;
    logic                ack_s2arb;
    logic [0:0]          grant_id;
    logic                busy;
`ifdef ARB_TIMEOUT_EN
    logic [N-1:0]        err_m;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dbus_rr_arbiter #(
        .N_CPU(N), .DBUS_AW(AW), .DBUS_DW(DW), .DBUS_ISEL(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_m2dbiu      (req),
        .adr_m2dbiu_flat (adr_flat),
        .dat_m2dbiu_flat (dat_flat),
        .we_m2dbiu       (we),
        .sel_m2dbiu_flat (sel_flat),
        .dat_dbiu2m_flat (rdat_flat),
        .ack_dbiu2m      (ack_m),
        .req_arb2s       (req_s),
        .adr_arb2s       (adr_s),
        .dat_arb2s       (dat_s),
        .we_arb2s        (we_s),
        .sel_arb2s       (sel_s),
        .dat_s2arb       (dat_s2arb),
        .ack_s2arb       (ack_s2arb),
        .grant_id        (grant_id),
        .busy            (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .err_dbiu2m      (err_m)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_ack(input logic [DW-1:0] d);
        ack_s2arb = 1'b1;
        dat_s2arb = d;
        tick();
        ack_s2arb = 1'b0;
        dat_s2arb = '0;
    endtask

    function automatic logic [63:0] rslice(input int g);
        return rdat_flat[g*DW +: DW];
    endfunction

    initial begin
        resetn    = 1'b0;
        req       = '0;
        adr_flat  = '0;
        dat_flat  = '0;
        we        = '0;
        sel_flat  = '0;
        dat_s2arb = '0;
        ack_s2arb = 1'b0;
        tick();
        tick();

        check("rst_req_s",  64'(req_s),    64'd0);
        check("rst_ack",    64'(ack_m),    64'd0);
        check("rst_grant",  64'(grant_id), 64'd0);
        check("rst_busy",   64'(busy),     64'd0);
        check("rst_rdat0",  rslice(0),     64'd0);
        resetn = 1'b1;
        tick();

        // Single load from CPU0, slave acks three cycles after grant.
        req[0] = 1'b1;
        adr_flat[0 +: AW] = 32'h0000_0000;
        we[0] = 1'b0;
        sel_flat[0 +: SW] = 8'hFF;
        check("load_pre_req", 64'(req_s), 64'd0);
        tick();
        check("load_req_s",  64'(req_s),    64'd1);
        check("load_busy",   64'(busy),     64'd1);
        check("load_grant",  64'(grant_id), 64'd0);
        check("load_sel",    64'(sel_s),    64'hFF);
        check("load_we",     64'(we_s),     64'd0);
        tick();
        tick();
        check("load_wait_ack", 64'(ack_m), 64'd0);
        slave_ack(64'h1122_3344_5566_7788);
        check("load_ack",    64'(ack_m),   64'b01);
        check("load_rdat",   rslice(0),    64'h1122_3344_5566_7788);
        check("load_req_dn", 64'(req_s),   64'd0);
        req[0] = 1'b0;
        tick();
        check("load_ack_1cy", 64'(ack_m), 64'd0);
        check("load_idle",    64'(busy),  64'd0);
        check("load_hold",    rslice(0),  64'h1122_3344_5566_7788);

        // Store from CPU0; requester keeps req high past the ack.
        req[0] = 1'b1;
        we[0] = 1'b1;
        dat_flat[0 +: DW] = 64'hFFFF_FFFF_FFFF_FFFF;
        sel_flat[0 +: SW] = 8'h3C;
        tick();
        check("st_dat", dat_s,           64'hFFFF_FFFF_FFFF_FFFF);
        check("st_we",  64'(we_s),       64'd1);
        check("st_sel", 64'(sel_s),      64'h3C);
        slave_ack(64'hDEAD_BEEF_0000_0001);
        check("st_ack",  64'(ack_m),     64'b01);
        check("st_rdat", rslice(0),      64'd0);
        tick();
        check("st_ack_1cy", 64'(ack_m),  64'd0);
        check("st_no_reiss", 64'(req_s), 64'd0);
        check("st_release",  64'(busy),  64'd1);
        tick();
        check("st_no_reiss2", 64'(req_s), 64'd0);
        req[0] = 1'b0;
        we[0] = 1'b0;
        tick();
        check("st_idle", 64'(busy), 64'd0);

        // Contention after a fresh reset: both request continuously, grants alternate 0,1,0,1.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        adr_flat[0 +: AW]  = 32'h0000_0100;
        adr_flat[AW +: AW] = 32'h0000_0200;
        req = 2'b11;
        for (int it = 0; it < 4; it++) begin
            int g;
            g = it % 2;
            tick();
            check($sformatf("rr_grant%0d", it), 64'(grant_id), 64'(g));
            check($sformatf("rr_adr%0d", it),   64'(adr_s),    (g == 0) ? 64'h100 : 64'h200);
            slave_ack(64'hA0 + 64'(it));
            check($sformatf("rr_ack%0d", it),   64'(ack_m),    64'(1 << g));
            check($sformatf("rr_rdat%0d", it),  rslice(g),     64'hA0 + 64'(it));
            req[g] = 1'b0;
            tick();
            req[g] = 1'b1;
        end
        req = '0;
        tick();

        // Field stability: winner's address changes mid-transaction.
        adr_flat[0 +: AW] = 32'h0000_0000;
        req[0] = 1'b1;
        tick();
        check("fs_grant", 64'(grant_id), 64'd0);
        adr_flat[0 +: AW] = 32'h0000_0040;
        tick();
        check("fs_adr1", 64'(adr_s), 64'd0);
        tick();
        check("fs_adr2", 64'(adr_s), 64'd0);
        slave_ack(64'h55);
        check("fs_ack", 64'(ack_m), 64'b01);
        req[0] = 1'b0;
        tick();

        // Reset in the middle of a CPU1 transaction, then a stray slave ack.
        adr_flat[AW +: AW] = 32'h0000_0080;
        req[1] = 1'b1;
        tick();
        check("rb_grant", 64'(grant_id), 64'd1);
        check("rb_busy",  64'(busy),     64'd1);
        req[1] = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rb_req_s", 64'(req_s),    64'd0);
        check("rb_grant0", 64'(grant_id), 64'd0);
        check("rb_busy0", 64'(busy),     64'd0);
        check("rb_adr",   64'(adr_s),    64'd0);
        check("rb_rdat1", rslice(1),     64'd0);
        slave_ack(64'h77);
        check("rb_stray_ack", 64'(ack_m), 64'd0);
        check("rb_stray_busy", 64'(busy), 64'd0);

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: watchdog fires TMO cycles after BUSY entry.
        req[0] = 1'b1;
        tick();
        for (int k = 1; k < TMO; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), 64'({err_m, ack_m}), 64'd0);
        end
        tick();
        check("to_ack",   64'(ack_m), 64'b01);
        check("to_err",   64'(err_m), 64'b01);
        check("to_rdat",  rslice(0),  64'hFFFF_FFFF_FFFF_FFFF);
        check("to_req_s", 64'(req_s), 64'd0);
        req[0] = 1'b0;
        tick();
        check("to_err_1cy", 64'(err_m), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
